// File: rtl/blkram_pkg.sv
// Shared types and helpers for the byte-enabled block RAM controller.
// Data widths up to MAX_DATA_W are handled by the byte merge helper.
package blkram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int NBYTES     = DEF_DATA_W / 8;

    localparam int MAX_DATA_W = 256;
    localparam int MAX_NBYTES = MAX_DATA_W / 8;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Callers zero-extend narrower words and take the low DATA_W bits back.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_NBYTES-1:0] we
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MAX_NBYTES; b++) begin
            if (we[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/blkram_array.sv
// Single-port storage: byte-enable write, read-first registered read, no reset.
// Read data appears one edge after re; the controller never presents out-of-range addresses.
module blkram_array
    import blkram_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH     = 512,
    parameter int    AW        = 9,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic [DATA_W/8-1:0]  we,
    input  logic [AW-1:0]        addr,
    input  logic [DATA_W-1:0]    wdat,
    input  logic                 re,
    output logic [DATA_W-1:0]    rdat
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdat_q;

    // Read samples the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdat_q <= mem[addr];
        end
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
            end
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/blkram_ctl.sv
// Block RAM controller: clear engine FSM, range check, optional forwarding (BLKRAM_WRITE_FORWARD_EN).
// Read data/rd_valid land RD_LAT edges after acceptance; requests during busy are dropped.
module blkram_ctl
    import blkram_pkg::*;
#(
    parameter int    DATA_W         = DEF_DATA_W,
    parameter int    DEPTH          = 512,
    parameter int    ADDR_W         = 12,
    parameter int    RD_LAT         = RD_LAT_MIN,
    parameter string INIT_FILE      = "",
    parameter int    CLEAR_ON_RESET = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 select,
    input  logic [DATA_W/8-1:0]  we,
    input  logic                 rd,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 busy
);

    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    state_e            state_q;
    logic [AW-1:0]     clr_cnt_q;

    logic              in_range;
    logic              rd_acc;
    logic              wr_acc;

    logic [NB-1:0]     arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_wdat;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdat;

    logic              rd_v0_q;
    logic              oor0_q;
    logic [DATA_W-1:0] rd_word;

    logic              out_v;
    logic [DATA_W-1:0] out_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign rd_acc   = (state_q == IDLE) && select && rd;
    assign wr_acc   = (state_q == IDLE) && select && (|we) && in_range;
    assign busy     = (state_q == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The clear engine owns the single RAM port while busy.
    always_comb begin
        arr_we   = '0;
        arr_addr = addr[AW-1:0];
        arr_wdat = data_in;
        arr_re   = rd_acc && in_range;
        if (state_q == CLEAR) begin
            arr_we   = '1;
            arr_addr = clr_cnt_q;
            arr_wdat = '0;
        end else if (wr_acc) begin
            arr_we = we;
        end
    end

    blkram_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (arr_addr),
        .wdat (arr_wdat),
        .re   (arr_re),
        .rdat (arr_rdat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v0_q <= 1'b0;
            oor0_q  <= 1'b0;
        end else begin
            rd_v0_q <= rd_acc;
            oor0_q  <= rd_acc && !in_range;
        end
    end

`ifdef BLKRAM_WRITE_FORWARD_EN
    logic [NB-1:0]         fwd_we_q;
    logic [DATA_W-1:0]     fwd_dat_q;
    logic [MAX_DATA_W-1:0] m_old;
    logic [MAX_DATA_W-1:0] m_new;
    logic [MAX_DATA_W-1:0] m_res;
    logic [MAX_NBYTES-1:0] m_we;

    // Single port, so a same-cycle read and write always target one address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_we_q  <= '0;
            fwd_dat_q <= '0;
        end else begin
            fwd_we_q  <= (rd_acc && wr_acc) ? we : '0;
            fwd_dat_q <= data_in;
        end
    end

    always_comb begin
        m_old               = '0;
        m_new               = '0;
        m_we                = '0;
        m_old[DATA_W-1:0]   = arr_rdat;
        m_new[DATA_W-1:0]   = fwd_dat_q;
        m_we[NB-1:0]        = fwd_we_q;
        m_res               = byte_merge(m_old, m_new, m_we);
        rd_word             = m_res[DATA_W-1:0];
        if (oor0_q) begin
            rd_word = '0;
        end
    end
`else
    always_comb begin
        rd_word = arr_rdat;
        if (oor0_q) begin
            rd_word = '0;
        end
    end
`endif

    generate
        if (RD_LAT > RD_LAT_MIN) begin : g_lat2
            logic              v1_q;
            logic [DATA_W-1:0] d1_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v1_q <= 1'b0;
                    d1_q <= '0;
                end else begin
                    v1_q <= rd_v0_q;
                    if (rd_v0_q) begin
                        d1_q <= rd_word;
                    end
                end
            end

            assign out_v = v1_q;
            assign out_d = d1_q;
        end else begin : g_lat1
            assign out_v = rd_v0_q;
            assign out_d = rd_word;
        end
    endgenerate

    assign data_out_d = out_v ? out_d : data_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_valid_q <= out_v;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_blkram_ctl.sv
// Directed bench: three controllers (RD_LAT=1, RD_LAT=2, DEPTH=300) driven in lock-step.
module tb_blkram_ctl;

`ifdef BLKRAM_WRITE_FORWARD_EN
    localparam logic [31:0] FWD_EXP = 32'hAAAA5678;
`else
    localparam logic [31:0] FWD_EXP = 32'hAAAAAAAA;
`endif

    logic        clk;
    logic        reset;
    logic        select;
    logic [3:0]  we;
    logic        rd;
    logic [11:0] addr;
    logic [31:0] data_in;

    logic [31:0] dout1, dout2, dout3;
    logic        v1, v2, v3;
    logic        busy1, busy2, busy3;

    int n_assert = 0;
    int n_fail   = 0;
    int bc1 = 0, bc2 = 0, bc3 = 0;

    blkram_ctl #(.DATA_W(32), .DEPTH(512), .ADDR_W(12), .RD_LAT(1), .INIT_FILE(""), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .select(select), .we(we), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(dout1), .rd_valid(v1), .busy(busy1));

    blkram_ctl #(.DATA_W(32), .DEPTH(512), .ADDR_W(12), .RD_LAT(2), .INIT_FILE(""), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .reset(reset), .select(select), .we(we), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(dout2), .rd_valid(v2), .busy(busy2));

    blkram_ctl #(.DATA_W(32), .DEPTH(300), .ADDR_W(12), .RD_LAT(1), .INIT_FILE(""), .CLEAR_ON_RESET(1)) dut3 (
        .clk(clk), .reset(reset), .select(select), .we(we), .rd(rd), .addr(addr),
        .data_in(data_in), .data_out(dout3), .rd_valid(v3), .busy(busy3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (reset) begin
            bc1 <= 0; bc2 <= 0; bc3 <= 0;
        end else begin
            if (busy1) bc1 <= bc1 + 1;
            if (busy2) bc2 <= bc2 + 1;
            if (busy3) bc3 <= bc3 + 1;
        end
    end

    typedef struct {
        logic        sel;
        logic        rd;
        logic [3:0]  we;
        logic [11:0] addr;
        logic [31:0] din;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_op(input logic s, input logic r, input logic [3:0] w,
                            input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        select = s; rd = r; we = w; addr = a; data_in = d;
        @(negedge clk);
        select = 1'b0; rd = 1'b0; we = 4'h0;
    endtask

    // Call straight after apply_op: RD_LAT=1 results one negedge later, RD_LAT=2 the next.
    task automatic check_lat(input string nm, input logic ev, input logic [31:0] ed,
                             input logic ev3, input logic [31:0] ed3);
        @(negedge clk);
        chk({nm, "/lat1_vld"}, 32'(v1), 32'(ev));
        chk({nm, "/lat1_dat"}, dout1, ed);
        chk({nm, "/d300_vld"}, 32'(v3), 32'(ev3));
        chk({nm, "/d300_dat"}, dout3, ed3);
        chk({nm, "/lat2_early"}, 32'(v2), 32'(0));
        @(negedge clk);
        chk({nm, "/lat2_vld"}, 32'(v2), 32'(ev));
        chk({nm, "/lat2_dat"}, dout2, ed);
        chk({nm, "/lat1_single"}, 32'(v1), 32'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;

        reset = 1'b1; select = 1'b0; we = 4'h0; rd = 1'b0; addr = '0; data_in = '0;

        vecs[0]  = '{1'b1, 1'b1, 4'h0, 12'd0,   32'h0,        1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'h0, 12'd255, 32'h0,        1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 12'd5,   32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 4'h0, 12'd511, 32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 4'hF, 12'd5,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 4'h2, 12'd5,   32'h0000AA00, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 4'h0, 12'd5,   32'h0,        1'b1, 32'hDEADAAEF};
        vecs[7]  = '{1'b1, 1'b0, 4'hF, 12'd9,   32'hAAAAAAAA, 1'b0, 32'hDEADAAEF};
        vecs[8]  = '{1'b1, 1'b1, 4'h3, 12'd9,   32'h12345678, 1'b1, FWD_EXP};
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 12'd9,   32'h0,        1'b1, 32'hAAAA5678};
        vecs[10] = '{1'b0, 1'b1, 4'h0, 12'd5,   32'h0,        1'b0, 32'hAAAA5678};
        vecs[11] = '{1'b0, 1'b0, 4'hF, 12'd5,   32'hFFFFFFFF, 1'b0, 32'hAAAA5678};
        vecs[12] = '{1'b1, 1'b1, 4'h0, 12'd5,   32'h0,        1'b1, 32'hDEADAAEF};
        for (int i = 0; i < 8; i++) begin
            vecs[13 + i] = '{1'b1, 1'b0, 4'hF, 12'(i), 32'h10 + 32'(i), 1'b0, 32'hDEADAAEF};
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy1", 32'(busy1), 32'(1));
        chk("rst_busy3", 32'(busy3), 32'(1));
        chk("rst_vld1", 32'(v1), 32'(0));
        chk("rst_vld2", 32'(v2), 32'(0));
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dout2", dout2, 32'h0);

        // Interrupt the first clear at cycle 100
        @(posedge clk); #2 reset = 1'b0;
        repeat (100) @(posedge clk);
        #1 chk("clear_c100_busy", 32'(busy1), 32'(1));
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'({busy1, busy2, busy3}), 32'(3'b111));
        chk("midrst_dout", dout1, 32'h0);
        @(posedge clk); #2 reset = 1'b0;

        // Request during busy must be dropped
        repeat (200) @(posedge clk);
        apply_op(1'b1, 1'b1, 4'hF, 12'd5, 32'hFFFFFFFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_req_novld", 32'({v1, v2, v3}), 32'(0));
        end

        guard = 0;
        while ((busy1 || busy2 || busy3) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("clear_done", 32'({busy1, busy2, busy3}), 32'(0));
        chk("busy_len_512_lat1", 32'(bc1), 32'(512));
        chk("busy_len_512_lat2", 32'(bc2), 32'(512));
        chk("busy_len_300", 32'(bc3), 32'(300));
        chk("post_clear_dout", dout1, 32'h0);

        for (int i = 0; i < 21; i++) begin
            apply_op(vecs[i].sel, vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].din);
            check_lat($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ev, vecs[i].ed);
        end

        // Back-to-back reads of 0..7, one per cycle
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("burst%0d_lat1_vld", j), 32'(v1), 32'((j >= 2 && j <= 9) ? 1 : 0));
            if (j >= 2 && j <= 9) chk($sformatf("burst%0d_lat1_dat", j), dout1, 32'h10 + 32'(j - 2));
            chk($sformatf("burst%0d_lat2_vld", j), 32'(v2), 32'((j >= 3 && j <= 10) ? 1 : 0));
            if (j >= 3 && j <= 10) chk($sformatf("burst%0d_lat2_dat", j), dout2, 32'h10 + 32'(j - 3));
            if (j < 8) begin
                select = 1'b1; rd = 1'b1; addr = 12'(j);
            end else begin
                select = 1'b0; rd = 1'b0;
            end
        end

        // addr == DEPTH on the 300-word instance
        apply_op(1'b1, 1'b0, 4'hF, 12'd300, 32'hCAFEF00D);
        check_lat("wr300", 1'b0, 32'h17, 1'b0, 32'h17);
        apply_op(1'b1, 1'b1, 4'h0, 12'd300, 32'h0);
        check_lat("rd300", 1'b1, 32'hCAFEF00D, 1'b1, 32'h0);
        apply_op(1'b1, 1'b1, 4'h0, 12'd7, 32'h0);
        check_lat("rd7", 1'b1, 32'h17, 1'b1, 32'h17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
